// File: rtl/extend_scheduler.sv
// Extend-lane sequencer: packs diagonal requests into NUM_EXTEND-slot bundles,
// writes them to the bundle FIFO and paces pops against lane completion.
module extend_scheduler #(
   parameter int NUM_EXTEND    = 8,
   parameter int LOG_TILE_SIZE = 9,
   parameter int TB_ADDR       = 10,
   parameter int FIFO_WIDTH    = 2*LOG_TILE_SIZE+TB_ADDR+2,
   parameter int FLUSH_TIMEOUT = 4,
   parameter int SETTLE        = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [LOG_TILE_SIZE:0]           req_k,
   input  logic [LOG_TILE_SIZE-1:0]         req_offset,
   input  logic [TB_ADDR-1:0]               req_tbaddr,
   input  logic                             flush,
   output logic                             fifo_wen,
   output logic [NUM_EXTEND*FIFO_WIDTH-1:0] fifo_din,
   input  logic                             fifo_full,
   input  logic                             fifo_empty,
   output logic                             fifo_ren,
   input  logic [NUM_EXTEND-1:0]            is_finish,
   input  logic                             load,
   output logic                             idle,
   output logic [15:0]                      bundles_issued
);
   localparam int CW = $clog2(NUM_EXTEND+1);
   localparam int TW = $clog2(FLUSH_TIMEOUT+1);
   localparam int SW = $clog2(SETTLE+1);
   localparam logic [CW-1:0] FULL_CNT    = CW'(NUM_EXTEND);
   localparam logic [TW-1:0] TIMEOUT     = TW'(FLUSH_TIMEOUT);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE-1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      POP       = 2'd1,
      SETTLING  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   logic [CW-1:0]                     slot_cnt_r;
   logic [TW-1:0]                     timer_r;
   logic [NUM_EXTEND*FIFO_WIDTH-1:0]  bundle_r;
   logic [SW-1:0]                     settle_cnt_r;
   logic [SW-1:0]                     settle_next_s;
   logic [15:0]                       bundles_issued_r;
   state_t                            state_r;
   state_t                            state_s;
   logic                              write_fire_s;
   logic                              accept_s;
   logic                              all_done_s;
   logic [FIFO_WIDTH-1:0]             slot_s;

   // Packer handshake and bundle write decision.
   always_comb begin
      all_done_s = &is_finish;
      slot_s     = {1'b1, req_k, req_offset, req_tbaddr};
      if (!rst && !fifo_full && (slot_cnt_r != '0) &&
          ((slot_cnt_r == FULL_CNT) || flush || (timer_r == TIMEOUT))) begin
         write_fire_s = 1'b1;
      end else begin
         write_fire_s = 1'b0;
      end
      req_ready = !rst && (slot_cnt_r < FULL_CNT) && !write_fire_s;
      accept_s  = req_valid && req_ready;
   end

   // Bundle register, fill count and partial-bundle idle timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_r <= '0;
         bundle_r   <= '0;
         timer_r    <= '0;
      end else begin
         if (write_fire_s) begin
            slot_cnt_r <= '0;
            bundle_r   <= '0;
         end else if (accept_s) begin
            for (int i = 0; i < NUM_EXTEND; i++) begin
               if (slot_cnt_r == CW'(i)) begin
                  bundle_r[i*FIFO_WIDTH +: FIFO_WIDTH] <= slot_s;
               end
            end
            slot_cnt_r <= slot_cnt_r + CW'(1);
         end
         if (accept_s || write_fire_s || (slot_cnt_r == '0)) begin
            timer_r <= '0;
         end else if (timer_r != TIMEOUT) begin
            timer_r <= timer_r + TW'(1);
         end
      end
   end

   // Issue FSM next state; the settle window hides lane latency after a pop.
   always_comb begin
      state_s       = state_r;
      settle_next_s = settle_cnt_r + SW'(1);
      case (state_r)
         IDLE: begin
            if (!fifo_empty && all_done_s && !load) begin
               state_s = POP;
            end else begin
               state_s = IDLE;
            end
         end
         POP: state_s = SETTLING;
         SETTLING: begin
            if (settle_next_s >= SETTLE_LAST) begin
               state_s = WAIT_DONE;
            end else begin
               state_s = SETTLING;
            end
         end
         WAIT_DONE: begin
            if (all_done_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Issue FSM state, settle counter and popped-bundle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         settle_cnt_r     <= '0;
         bundles_issued_r <= 16'd0;
      end else begin
         state_r <= state_s;
         case (state_r)
            POP: begin
               settle_cnt_r     <= '0;
               bundles_issued_r <= bundles_issued_r + 16'd1;
            end
            SETTLING: settle_cnt_r <= settle_next_s;
            default:  settle_cnt_r <= settle_cnt_r;
         endcase
      end
   end

   assign fifo_wen       = write_fire_s;
   assign fifo_din       = bundle_r;
   assign fifo_ren       = (state_r == POP) && !rst;
   assign bundles_issued = bundles_issued_r;
   assign idle           = !rst && (slot_cnt_r == '0) && fifo_empty &&
                           (state_r == IDLE) && all_done_s;

endmodule

// File: tb/tb_extend_scheduler.sv
// Directed bench for extend_scheduler: packing, timeout, back-pressure,
// flush, load gating, pop pacing and mid-operation reset.
module tb_extend_scheduler;
   localparam int NE = 8;
   localparam int LT = 9;
   localparam int TA = 10;
   localparam int FW = 2*LT+TA+2;
   localparam int BW = NE*FW;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [LT:0]   req_k;
   logic [LT-1:0] req_offset;
   logic [TA-1:0] req_tbaddr;
   logic          flush;
   logic          fifo_wen;
   logic [BW-1:0] fifo_din;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_ren;
   logic [NE-1:0] is_finish;
   logic          load;
   logic          idle;
   logic [15:0]   bundles_issued;

   int            n_checks = 0;
   int            n_err    = 0;
   logic [BW-1:0] exp_b;

   extend_scheduler #(
      .NUM_EXTEND(NE), .LOG_TILE_SIZE(LT), .TB_ADDR(TA),
      .FIFO_WIDTH(FW), .FLUSH_TIMEOUT(4), .SETTLE(3)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_k(req_k), .req_offset(req_offset), .req_tbaddr(req_tbaddr),
      .flush(flush), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
      .is_finish(is_finish), .load(load), .idle(idle),
      .bundles_issued(bundles_issued)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk_slot(input int k, input int o, input int t);
      logic [LT:0]   kk;
      logic [LT-1:0] oo;
      logic [TA-1:0] tt;
      kk = k[LT:0];
      oo = o[LT-1:0];
      tt = t[TA-1:0];
      return {1'b1, kk, oo, tt};
   endfunction

   task automatic drive_req(input int k, input int o, input int t);
      req_valid  = 1'b1;
      req_k      = k[LT:0];
      req_offset = o[LT-1:0];
      req_tbaddr = t[TA-1:0];
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_k = '0; req_offset = '0; req_tbaddr = '0;
      flush = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1; is_finish = 8'hFF; load = 1'b0;
      tick(); #1;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_wen", fifo_wen, 1'b0);
      chk("rst_ren", fifo_ren, 1'b0);
      chk("rst_idle", idle, 1'b0);
      tick(); rst = 1'b0; #1;
      chk("reset_count", bundles_issued, 16'd0);
      chk("reset_din", fifo_din, 0);
      chk("reset_idle", idle, 1'b1);
      chk("reset_ready", req_ready, 1'b1);

      // Full bundle of 8 back-to-back requests.
      exp_b = '0;
      for (int i = 0; i < 8; i++) begin
         drive_req(i, 16*i, i);
         exp_b[i*FW +: FW] = mk_slot(i, 16*i, i);
         #1;
         chk("full_ready", req_ready, 1'b1);
         chk("full_no_wen", fifo_wen, 1'b0);
         tick();
      end
      req_valid = 1'b0; #1;
      chk("full_wen", fifo_wen, 1'b1);
      chk("full_ready_low", req_ready, 1'b0);
      chk("full_din", fifo_din, exp_b);
      tick(); #1;
      chk("full_wen_pulse", fifo_wen, 1'b0);
      chk("full_cleared", fifo_din, 0);

      // Partial bundle flushed by the idle timeout.
      exp_b = '0;
      for (int i = 0; i < 3; i++) begin
         drive_req(20+i, 100+i, 300+i);
         exp_b[i*FW +: FW] = mk_slot(20+i, 100+i, 300+i);
         #1;
         chk("part_ready", req_ready, 1'b1);
         tick();
      end
      req_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("part_wait", fifo_wen, 1'b0);
         tick();
      end
      #1;
      chk("part_wen", fifo_wen, 1'b1);
      chk("part_din", fifo_din, exp_b);
      tick();

      // Back-pressure: fill under fifo_full, hold, release.
      fifo_full = 1'b1;
      exp_b = '0;
      for (int i = 0; i < 8; i++) begin
         drive_req(40+i, 3*i, 5*i+1);
         exp_b[i*FW +: FW] = mk_slot(40+i, 3*i, 5*i+1);
         #1;
         chk("bp_fill_ready", req_ready, 1'b1);
         tick();
      end
      req_valid = 1'b0;
      for (int j = 0; j < 10; j++) begin
         #1;
         chk("bp_hold_wen", fifo_wen, 1'b0);
         chk("bp_hold_ready", req_ready, 1'b0);
         tick();
      end
      fifo_full = 1'b0; #1;
      chk("bp_release_wen", fifo_wen, 1'b1);
      chk("bp_release_din", fifo_din, exp_b);
      tick(); #1;
      chk("bp_after", fifo_wen, 1'b0);

      // Flush: ignored when empty, forces a partial write otherwise.
      flush = 1'b1; #1;
      chk("flush_empty", fifo_wen, 1'b0);
      tick(); flush = 1'b0;
      exp_b = '0;
      for (int i = 0; i < 2; i++) begin
         drive_req(500+i, 7+i, 900+i);
         exp_b[i*FW +: FW] = mk_slot(500+i, 7+i, 900+i);
         tick();
      end
      req_valid = 1'b0; flush = 1'b1; #1;
      chk("flush_wen", fifo_wen, 1'b1);
      chk("flush_din", fifo_din, exp_b);
      tick(); flush = 1'b0; #1;
      chk("flush_after", fifo_wen, 1'b0);
      chk("flush_idle", idle, 1'b1);

      // Load gating, then waiting on lane completion.
      fifo_empty = 1'b0; load = 1'b1; #1;
      chk("load_block", fifo_ren, 1'b0);
      for (int j = 0; j < 3; j++) begin
         tick(); #1;
         chk("load_block", fifo_ren, 1'b0);
      end
      load = 1'b0; #1;
      chk("load_fall_same", fifo_ren, 1'b0);
      tick(); #1;
      chk("load_pop", fifo_ren, 1'b1);
      chk("load_pop_cnt", bundles_issued, 16'd0);
      tick(); is_finish = 8'hFE; #1;
      chk("pop_pulse", fifo_ren, 1'b0);
      chk("pop_cnt", bundles_issued, 16'd1);
      for (int j = 0; j < 4; j++) begin
         tick(); #1;
         chk("busy_no_pop", fifo_ren, 1'b0);
      end
      tick(); is_finish = 8'hFF; #1;
      chk("done_no_pop", fifo_ren, 1'b0);
      tick(); #1;
      chk("idle_no_pop", fifo_ren, 1'b0);
      tick(); #1;
      chk("second_pop", fifo_ren, 1'b1);
      fifo_empty = 1'b1;
      tick(); #1;
      chk("second_cnt", bundles_issued, 16'd2);

      // Back-to-back pop spacing from a fresh reset.
      rst = 1'b1;
      tick(); rst = 1'b0; #1;
      chk("b2b_reset_cnt", bundles_issued, 16'd0);
      fifo_empty = 1'b0; #1;
      chk("b2b_pre", fifo_ren, 1'b0);
      tick(); #1;
      chk("b2b_pop1", fifo_ren, 1'b1);
      for (int j = 0; j < 4; j++) begin
         tick(); #1;
         chk("b2b_gap", fifo_ren, 1'b0);
      end
      tick(); #1;
      chk("b2b_pop2", fifo_ren, 1'b1);
      fifo_empty = 1'b1;
      tick(); #1;
      chk("b2b_cnt", bundles_issued, 16'd2);

      // Reset with a partial bundle pending and the FSM in WAIT_DONE.
      tick(); tick(); tick();
      fifo_empty = 1'b0;
      tick(); #1;
      chk("mid_pop", fifo_ren, 1'b1);
      fifo_empty = 1'b1; is_finish = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         drive_req(60+i, 9*i, 11*i);
         #1;
         chk("mid_fill_ready", req_ready, 1'b1);
      end
      tick(); req_valid = 1'b0; #1;
      chk("mid_cnt", bundles_issued, 16'd3);
      chk("mid_no_wen", fifo_wen, 1'b0);
      rst = 1'b1; #1;
      chk("mid_rst_wen", fifo_wen, 1'b0);
      chk("mid_rst_ren", fifo_ren, 1'b0);
      chk("mid_rst_ready", req_ready, 1'b0);
      tick(); rst = 1'b0; is_finish = 8'hFF; #1;
      chk("mid_idle", idle, 1'b1);
      chk("mid_din", fifo_din, 0);
      chk("mid_cnt_clr", bundles_issued, 16'd0);
      chk("mid_ren", fifo_ren, 1'b0);
      for (int j = 0; j < 6; j++) begin
         tick(); #1;
         chk("mid_dropped", fifo_wen, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
